// File: rtl/delay_pipe.sv
// delay_pipe: stallable DEPTH-stage delay line carrying a data word plus a
// valid flag. Used to skew operands and partial products between rows of the
// finite-field systolic multiplier.
//
// Optional feature macro: DELAY_PIPE_OCC_EN
//   defined     -> occ counts the stages holding valid data; empty = (occ == 0)
//   not defined -> counter compiled out, occ tied to 0, empty tied to 1
//
// Valid semantics: in_vld qualifies d on any rising edge where en = 1 and
// flush = 0. There is no ready; the pipe always accepts, and the word in the
// last stage is dropped on every advance. out_vld qualifies q for as long as
// it is held.
module delay_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int OCCW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [1:WIDTH]   d,
  input  logic             in_vld,
  output logic [1:WIDTH]   q,
  output logic             out_vld,
  output logic [OCCW-1:0]  occ,
  output logic             empty
);

  // Stage 1 is the input end, stage DEPTH drives q/out_vld.
  logic [1:WIDTH] stage_data [1:DEPTH];
  logic           stage_vld  [1:DEPTH];

  // Shift register: flush clears, en advances, otherwise hold. Bubbles enter
  // as zero data so downstream rows never see stale operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_data[k] <= '0;
        stage_vld[k]  <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_data[k] <= '0;
        stage_vld[k]  <= 1'b0;
      end
    end else if (en) begin
      stage_data[1] <= in_vld ? d : '0;
      stage_vld[1]  <= in_vld;
      for (int k = 2; k <= DEPTH; k++) begin
        stage_data[k] <= stage_data[k-1];
        stage_vld[k]  <= stage_vld[k-1];
      end
    end
  end

  assign q       = stage_data[DEPTH];
  assign out_vld = stage_vld[DEPTH];

`ifdef DELAY_PIPE_OCC_EN
  logic [OCCW-1:0] occ_r;

  // Occupancy tracks entries minus exits on each advance; a simultaneous
  // entry and exit leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= '0;
    end else if (flush) begin
      occ_r <= '0;
    end else if (en) begin
      case ({in_vld, stage_vld[DEPTH]})
        2'b10:   occ_r <= occ_r + OCCW'(1);
        2'b01:   occ_r <= occ_r - OCCW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign occ   = occ_r;
  assign empty = (occ_r == '0);
`else
  assign occ   = '0;
  assign empty = 1'b1;
`endif

endmodule
